shift_sequencer: RTL and testbench

Multi-cycle 32-bit shift/rotate unit that reuses one single-bit shift stage, stepping it once per clock, instead of a full combinational barrel shifter. It serves ALU shift instructions (SLL, SRL, SRA) and the SHA-256 rotate-right (ROTR) operations of the miner datapath. Area stays small at the cost of a latency of shamt+1 cycles. A start/busy/done handshake lets the pipeline controller stall while a shift is in flight.

---
 rtl/shift_sequencer_if.sv | 44 ++++
 rtl/shift_sequencer.sv | 125 ++++++++++++
 tb/tb_shift_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// -----------------------------------------------------------------------------
// shift_sequencer_if
//
// This interface carries the request and response signals of the multi-cycle
// shift/rotate unit. The clock and reset are not part of it; they are plain
// ports on the sequencer.
//
//   start    master -> slave  request; sampled only while the unit is idle
//   op       master -> slave  00 SLL, 01 SRL, 10 SRA, 11 ROTR
//   data_in  master -> slave  32-bit operand
//   shamt    master -> slave  shift amount, 0..31
//   busy     slave -> master  high while an operation is in flight
//   done     slave -> master  one-cycle completion pulse
//   result   slave -> master  last completed result; held between completions
// -----------------------------------------------------------------------------
interface shift_sequencer_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start,
        output op,
        output data_in,
        output shamt,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  op,
        input  data_in,
        input  shamt,
        output busy,
        output done,
        output result
    );
endinterface

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// This is a 32-bit shift/rotate unit for the ALU shift instructions (SLL, SRL,
// SRA) and for the SHA-256 ROTR operations. It does not use a full barrel
// shifter. It contains one single-bit shift stage and applies that stage once
// per clock. An operation with amount shamt completes in cycle shamt+1 after
// start is accepted. The shamt=0 case is a passthrough that completes in
// cycle 1.
//
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous, active-high; discards any operation in flight and
//           clears result
//   bus     slave side of shift_sequencer_if:
//             start/op/data_in/shamt  request; the unit latches these at
//                                     acceptance
//             busy/done/result        registered status and result
// -----------------------------------------------------------------------------
module shift_sequencer (
    input  logic              clock,
    input  logic              reset,
    shift_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_ROTR = 2'b11
    } op_t;

    state_t      state;
    logic [31:0] work;
    logic [4:0]  count;
    op_t         op_q;

    // This is the single one-bit shift stage. It is shared by all four
    // operations.
    function automatic logic [31:0] step(input op_t o, input logic [31:0] w);
        logic [31:0] r;
        r = w;
        case (o)
            OP_SLL:  r = {w[30:0], 1'b0};
            OP_SRL:  r = {1'b0, w[31:1]};
            OP_SRA:  r = {w[31], w[31:1]};
            OP_ROTR: r = {w[0], w[31:1]};
            default: r = w;
        endcase
        return r;
    endfunction

    logic [31:0] work_next;
    always_comb begin
        work_next = step(op_q, work);
    end

    // busy, done and result are registered here together with the state.
    // Because of this, no input reaches an output in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            work       <= '0;
            count      <= '0;
            op_q       <= OP_SLL;
            bus.result <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        work     <= bus.data_in;
                        count    <= bus.shamt;
                        op_q     <= op_t'(bus.op);
                        bus.busy <= 1'b1;
                        if (bus.shamt == 5'd0) begin
                            // The passthrough case skips SHIFT. result is
                            // loaded on the same edge that enters DONE.
                            state      <= DONE;
                            bus.result <= bus.data_in;
                            bus.done   <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
                    work  <= work_next;
                    count <= count - 5'd1;
                    if (count == 5'd1) begin
                        // This is the last step. result takes the stepped
                        // value directly, so it is valid while done is high.
                        state      <= DONE;
                        bus.result <= work_next;
                        bus.done   <= 1'b1;
                    end
                end

                DONE: begin
                    // start is ignored here. The unit always returns to IDLE
                    // for one cycle before it can accept another request.
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    logic clock;
    logic reset;
    shift_sequencer_if bus ();

    shift_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation for every done pulse that it observes.
    logic prev_done = 1'b0;
    always @(negedge clock) begin
        if (!reset && bus.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_at_done", bus.result, e.res);
                check("done_cycle", cyc, e.at);
                check("busy_at_done", {31'd0, bus.busy}, 32'd1);
            end
            if (prev_done) check("done_back_to_back", 32'd1, 32'd0);
        end
        prev_done = bus.done;
    end

    // Asserts start in cycle c0 (it is sampled at the edge that ends c0).
    // The task returns at the negedge of cycle c0+1.
    task automatic start_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s,
                            input logic [31:0] req, output int c0);
        exp_t e;
        @(negedge clock);
        bus.op      = op;
        bus.data_in = d;
        bus.shamt   = s;
        bus.start   = 1'b1;
        c0          = cyc;
        e.res       = req;
        e.at        = c0 + int'(s) + 1;
        sb.push_back(e);
        @(negedge clock);
        bus.start   = 1'b0;
        bus.op      = 2'($urandom);
        bus.data_in = $urandom;
        bus.shamt   = 5'($urandom);
        check("busy_cycle1", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic finish_op(input int c0, input logic [4:0] s, input logic [31:0] req);
        int n = 0;
        while (cyc < c0 + int'(s) + 2 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) begin
            check("completion_timeout", 32'd1, 32'd0);
        end else begin
            check("busy_after_done", {31'd0, bus.busy}, 32'd0);
            check("result_held", bus.result, req);
            check("scoreboard_drained", sb.size(), 32'd0);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s,
                          input logic [31:0] req);
        int c0;
        start_op(op, d, s, req, c0);
        finish_op(c0, s, req);
    endtask

    initial begin
        int c0;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.data_in = '0;
        bus.shamt   = '0;
        reset       = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_result", bus.result, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        run_op(2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000);
        run_op(2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001);
        run_op(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000);
        run_op(2'b11, 32'h1234_5678, 5'd8,  32'h7812_3456);
        run_op(2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000);
        run_op(2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
        run_op(2'b10, 32'h7FFF_FFFF, 5'd4,  32'h07FF_FFFF);
        run_op(2'b00, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5);

        // Test that start is ignored while the unit is busy, including the
        // DONE cycle.
        start_op(2'b00, 32'h0000_0001, 5'd3, 32'h0000_0008, c0);
        @(negedge clock);
        bus.data_in = 32'hFFFF_FFFF; bus.shamt = 5'd1; bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        bus.data_in = 32'hFFFF_FFFF; bus.shamt = 5'd1; bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        finish_op(c0, 5'd3, 32'h0000_0008);
        repeat (4) begin
            @(negedge clock);
            check("idle_after_ignored", {31'd0, bus.busy}, 32'd0);
        end

        // Test a reset that arrives while an operation is in flight.
        start_op(2'b01, 32'hFFFF_FFFF, 5'd20, 32'h0000_0FFF, c0);
        while (cyc < c0 + 7) @(negedge clock);
        #2 reset = 1'b1;
        sb.delete();
        #1;
        check("midreset_busy", {31'd0, bus.busy}, 32'd0);
        check("midreset_done", {31'd0, bus.done}, 32'd0);
        check("midreset_result", bus.result, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        run_op(2'b10, 32'hFFFF_FF00, 5'd8, 32'hFFFF_FFFF);

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
